alarm_ringer: RTL and testbench
===============================

Name: alarm_ringer

Overview:
Downstream consumer of the alarm sequencer's state output. Compares running BCD time against the stored alarm time. While the sequencer reports the alarm armed, it fires the buzzer at HH:MM:00 and rings for a bounded time. Supports stop and snooze from debounced one-cycle button pulses. Drives buzzer pin and status LEDs.

Parameters:
RING_SEC, 60, EN_1HZ pulses a ring lasts before auto-stop (1..255)
SNOOZE_SEC, 300, EN_1HZ pulses spent in snooze before re-ringing (1..1023)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
EN_1HZ  in  1  one-CLK pulse per second, coincident with time update
EN_TONE  in  1  one-CLK pulse at 2x buzzer tone frequency
ALARM_STATE  in  2  sequencer state (ALARM_OFF / NOT_ALARM_DURING / ALARM_DURING)
HOUR_BCD  in  8  current hour, BCD 00-23
MIN_BCD  in  8  current minute, BCD 00-59
SEC_BCD  in  8  current second, BCD 00-59
ALM_HOUR  in  8  alarm hour, BCD
ALM_MIN  in  8  alarm minute, BCD
STOP_BTN  in  1  debounced one-cycle stop pulse
SNOOZE_BTN  in  1  debounced one-cycle snooze pulse
BUZZER  out  1  square-wave tone to piezo
RINGING  out  1  high in RING state
SNOOZING  out  1  high in SNOOZE state

Behaviour:
- Reset (async): state IDLE, ring_cnt=0, snz_cnt=0, match_q=0, BUZZER=0, RINGING=0, SNOOZING=0.
- armed = (ALARM_STATE == ALARM_DURING). match = armed & HOUR_BCD==ALM_HOUR & MIN_BCD==ALM_MIN & SEC_BCD==8'h00.
- match_q is match registered every CLK. trig = match & ~match_q. There is exactly one trigger per minute match, even though SEC stays 00 for a full second.
- FSM states: IDLE, RING, SNOOZE. All outputs are registered Moore outputs.
  - IDLE -> RING on trig. ring_cnt is cleared. RINGING=1 the cycle after trig is seen.
  - RING:
    - Each EN_1HZ increments ring_cnt.
    - If EN_1HZ and ring_cnt==RING_SEC-1: -> IDLE.
    - SNOOZE_BTN: -> SNOOZE, snz_cnt=0.
    - STOP_BTN: -> IDLE.
  - SNOOZE:
    - Each EN_1HZ increments snz_cnt.
    - If EN_1HZ and snz_cnt==SNOOZE_SEC-1: -> RING with ring_cnt=0.
    - STOP_BTN: -> IDLE.
    - SNOOZE_BTN: ignored.
- Priority, highest first, in every state: ~armed -> IDLE; STOP_BTN; SNOOZE_BTN; timeout; trig.
  - trig is ignored in RING and SNOOZE.
  - STOP and SNOOZE in the same cycle: STOP wins.
  - STOP coincident with snooze expiry: IDLE.
- BUZZER:
  - In RING, toggles on each EN_TONE.
  - Outside RING, 0 on the first cycle after leaving RING.
  - Starts at 0 on every entry into RING.
- Counter widths: ring_cnt 8 bit, snz_cnt 10 bit. Both only count in their own state, so there is no wrap.
- Disarm mid-ring or mid-snooze: IDLE next cycle, BUZZER=0.
- Reset mid-ring: outputs 0 immediately (async).
- Re-arm while time still matches: a trig can occur if match rises. This is intended.

Decomposition:
- Shared include param.v holds the ALARM_STATE encodings: ALARM_OFF=2'b00, NOT_ALARM_DURING=2'b01, ALARM_DURING=2'b10.
- It also holds the ringer state codes: R_IDLE=2'b00, R_RING=2'b01, R_SNOOZE=2'b10.
- One natural sub-module: alarm_match (combinational BCD compare plus match_q edge register, producing trig).
- The FSM, counters and tone toggle stay in alarm_ringer.

Test Plan:
- Common setup for all scenarios: RING_SEC=4, SNOOZE_SEC=3, ALARM_STATE=ALARM_DURING, ALM=07:30.
- Time steps 07:29:59 -> 07:30:00 on EN_1HZ -> RINGING=1 next cycle; BUZZER toggles per EN_TONE; after 4 EN_1HZ pulses, RINGING=0 and BUZZER=0.
- Ringing, SNOOZE_BTN pulse -> SNOOZING=1, BUZZER=0; after 3 EN_1HZ pulses, RINGING=1 again with full 4 s ring.
- Ringing, STOP_BTN and SNOOZE_BTN in the same cycle -> IDLE. SEC stays 00 for remaining cycles -> no retrigger.
- Ringing, ALARM_STATE -> NOT_ALARM_DURING -> IDLE next cycle. Time 07:30:00 with ALARM_STATE=ALARM_OFF -> no ring.
- Assert RESET mid-ring, between clock edges -> BUZZER/RINGING/SNOOZING=0 immediately. After release, state IDLE; the 07:30:00 trig fires only on a fresh match rise.
- Time 17:30:00 with ALM=07:30 (BCD hour mismatch in upper nibble) -> no ring.

Source files
------------

// File: rtl/alarm_ringer_pkg.sv
// Shared encodings for the alarm ringer: sequencer state codes and ringer FSM states.
package alarm_ringer_pkg;

    // Alarm sequencer state, as reported on ALARM_STATE
    localparam logic [1:0] ALARM_OFF        = 2'b00;
    localparam logic [1:0] NOT_ALARM_DURING = 2'b01;
    localparam logic [1:0] ALARM_DURING     = 2'b10;

    // Ringer FSM state codes
    typedef enum logic [1:0] {
        R_IDLE   = 2'b00,
        R_RING   = 2'b01,
        R_SNOOZE = 2'b10
    } ring_state_e;

endpackage

// File: rtl/alarm_ringer_match.sv
// BCD compare of running time against alarm time at second 00, with a
// registered copy of the match so only its rising edge produces a trigger.
module alarm_match (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       armed,
    input  logic [7:0] hour_bcd,
    input  logic [7:0] min_bcd,
    input  logic [7:0] sec_bcd,
    input  logic [7:0] alm_hour,
    input  logic [7:0] alm_min,
    output logic       trig
);

    logic match_d;
    logic match_q;

    // Whole-byte compares, so a mismatch in either BCD nibble blocks the match
    always_comb begin
        match_d = armed && (hour_bcd == alm_hour) && (min_bcd == alm_min) &&
                  (sec_bcd == 8'h00);
    end

    // Previous-cycle match, for edge detection while SEC sits at 00 for a second
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) match_q <= 1'b0;
        else       match_q <= match_d;
    end

    assign trig = match_d & ~match_q;

endmodule

// File: rtl/alarm_ringer.sv
// Alarm ringer: fires on the alarm minute while armed, rings for RING_SEC seconds,
// supports stop and snooze, and drives a square-wave buzzer plus status LEDs.
module alarm_ringer
    import alarm_ringer_pkg::*;
#(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       EN_1HZ,
    input  logic       EN_TONE,
    input  logic [1:0] ALARM_STATE,
    input  logic [7:0] HOUR_BCD,
    input  logic [7:0] MIN_BCD,
    input  logic [7:0] SEC_BCD,
    input  logic [7:0] ALM_HOUR,
    input  logic [7:0] ALM_MIN,
    input  logic       STOP_BTN,
    input  logic       SNOOZE_BTN,
    output logic       BUZZER,
    output logic       RINGING,
    output logic       SNOOZING
);

    localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);
    localparam logic [9:0] SNZ_LAST  = 10'(SNOOZE_SEC - 1);

    logic        armed;
    logic        trig;
    ring_state_e state_d, state_q;
    logic [7:0]  ring_cnt_d, ring_cnt_q;
    logic [9:0]  snz_cnt_d, snz_cnt_q;
    logic        buzzer_d, buzzer_q;

    assign armed = (ALARM_STATE == ALARM_DURING);

    alarm_match u_match (
        .CLK      (CLK),
        .RESET    (RESET),
        .armed    (armed),
        .hour_bcd (HOUR_BCD),
        .min_bcd  (MIN_BCD),
        .sec_bcd  (SEC_BCD),
        .alm_hour (ALM_HOUR),
        .alm_min  (ALM_MIN),
        .trig     (trig)
    );

    // Next state and counters; disarm overrides everything, then stop, snooze, timeout, trig
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        case (state_q)
            R_IDLE: begin
                if (trig) begin
                    state_d    = R_RING;
                    ring_cnt_d = 8'd0;
                end
            end
            R_RING: begin
                if (STOP_BTN) begin
                    state_d = R_IDLE;
                end else if (SNOOZE_BTN) begin
                    state_d   = R_SNOOZE;
                    snz_cnt_d = 10'd0;
                end else if (EN_1HZ) begin
                    if (ring_cnt_q == RING_LAST) state_d = R_IDLE;
                    else                         ring_cnt_d = ring_cnt_q + 8'd1;
                end
            end
            R_SNOOZE: begin
                if (STOP_BTN) begin
                    state_d = R_IDLE;
                end else if (EN_1HZ) begin
                    if (snz_cnt_q == SNZ_LAST) begin
                        state_d    = R_RING;
                        ring_cnt_d = 8'd0;
                    end else begin
                        snz_cnt_d = snz_cnt_q + 10'd1;
                    end
                end
            end
            default: state_d = R_IDLE;
        endcase
        if (!armed) state_d = R_IDLE;
    end

    // Tone toggles only while staying in RING, so every entry starts low and any exit drops it
    always_comb begin
        buzzer_d = 1'b0;
        if (state_q == R_RING && state_d == R_RING) buzzer_d = buzzer_q ^ EN_TONE;
    end

    // State, counters and buzzer registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= R_IDLE;
            ring_cnt_q <= 8'd0;
            snz_cnt_q  <= 10'd0;
            buzzer_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            buzzer_q   <= buzzer_d;
        end
    end

    assign BUZZER   = buzzer_q;
    assign RINGING  = (state_q == R_RING);
    assign SNOOZING = (state_q == R_SNOOZE);

endmodule

// File: tb/tb_alarm_ringer.sv
// Scripted scoreboard bench for alarm_ringer: each driven cycle pushes the expected
// {RINGING, SNOOZING, BUZZER} and the value is popped and compared one edge later.
module tb_alarm_ringer;
    import alarm_ringer_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       EN_1HZ, EN_TONE, STOP_BTN, SNOOZE_BTN;
    logic [1:0] ALARM_STATE;
    logic [7:0] HOUR_BCD, MIN_BCD, SEC_BCD, ALM_HOUR, ALM_MIN;
    logic       BUZZER, RINGING, SNOOZING;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    alarm_ringer #(.RING_SEC(4), .SNOOZE_SEC(3)) dut (
        .CLK(CLK), .RESET(RESET), .EN_1HZ(EN_1HZ), .EN_TONE(EN_TONE),
        .ALARM_STATE(ALARM_STATE), .HOUR_BCD(HOUR_BCD), .MIN_BCD(MIN_BCD),
        .SEC_BCD(SEC_BCD), .ALM_HOUR(ALM_HOUR), .ALM_MIN(ALM_MIN),
        .STOP_BTN(STOP_BTN), .SNOOZE_BTN(SNOOZE_BTN),
        .BUZZER(BUZZER), .RINGING(RINGING), .SNOOZING(SNOOZING)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got ring/snz/buz=%b expected %b", tag, act, exp);
        end
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        HOUR_BCD = h; MIN_BCD = m; SEC_BCD = s;
    endtask

    // Drive one cycle of inputs from a negedge; compare outputs at the next negedge
    task automatic tick(input string tag, input logic e1, input logic et,
                        input logic stp, input logic snz, input logic [2:0] exp);
        logic [2:0] e;
        EN_1HZ = e1; EN_TONE = et; STOP_BTN = stp; SNOOZE_BTN = snz;
        exp_q.push_back(exp);
        @(negedge CLK);
        e = exp_q.pop_front();
        chk(tag, {RINGING, SNOOZING, BUZZER}, e);
    endtask

    // Arm from 07:29:59 and roll to 07:30:00 so the trigger fires
    task automatic fire(input string tag);
        set_time(8'h07, 8'h29, 8'h59);
        tick({tag, "_pre"}, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        set_time(8'h07, 8'h30, 8'h00);
        tick({tag, "_trig"}, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100);
    endtask

    initial begin
        RESET = 1'b1;
        EN_1HZ = 1'b0; EN_TONE = 1'b0; STOP_BTN = 1'b0; SNOOZE_BTN = 1'b0;
        ALARM_STATE = ALARM_DURING;
        ALM_HOUR = 8'h07; ALM_MIN = 8'h30;
        set_time(8'h07, 8'h29, 8'h58);
        #1 chk("reset", {RINGING, SNOOZING, BUZZER}, 3'b000);
        @(negedge CLK);
        chk("reset_hold", {RINGING, SNOOZING, BUZZER}, 3'b000);
        RESET = 1'b0;

        // Basic ring: tone toggling, then auto-stop after 4 seconds
        fire("ring");
        tick("tone1", 1'b0, 1'b1, 1'b0, 1'b0, 3'b101);
        tick("tone2", 1'b0, 1'b1, 1'b0, 1'b0, 3'b100);
        tick("tone3", 1'b0, 1'b1, 1'b0, 1'b0, 3'b101);
        tick("tone_hold", 1'b0, 1'b0, 1'b0, 1'b0, 3'b101);
        set_time(8'h07, 8'h30, 8'h01);
        tick("sec1", 1'b1, 1'b0, 1'b0, 1'b0, 3'b101);
        tick("sec2", 1'b1, 1'b0, 1'b0, 1'b0, 3'b101);
        tick("sec3", 1'b1, 1'b1, 1'b0, 1'b0, 3'b100);
        tick("ring_end", 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
        tick("idle_after", 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);

        // Snooze, snooze button ignored while snoozing, re-ring for a full 4 s
        fire("snz");
        tick("snz_tone", 1'b0, 1'b1, 1'b0, 1'b0, 3'b101);
        tick("snz_enter", 1'b0, 1'b1, 1'b0, 1'b1, 3'b010);
        tick("snz_ignore", 1'b0, 1'b1, 1'b0, 1'b1, 3'b010);
        set_time(8'h07, 8'h30, 8'h01);
        tick("snz_s1", 1'b1, 1'b0, 1'b0, 1'b0, 3'b010);
        tick("snz_s2", 1'b1, 1'b0, 1'b0, 1'b0, 3'b010);
        tick("snz_wake", 1'b1, 1'b1, 1'b0, 1'b0, 3'b100);
        tick("re_tone", 1'b0, 1'b1, 1'b0, 1'b0, 3'b101);
        tick("re_s1", 1'b1, 1'b0, 1'b0, 1'b0, 3'b101);
        tick("re_s2", 1'b1, 1'b0, 1'b0, 1'b0, 3'b101);
        tick("re_s3", 1'b1, 1'b0, 1'b0, 1'b0, 3'b101);
        tick("re_end", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);

        // Stop and snooze together: stop wins; SEC stays 00 without retrigger
        fire("both");
        tick("both_btn", 1'b0, 1'b1, 1'b1, 1'b1, 3'b000);
        for (int i = 0; i < 3; i++) tick("no_retrig", 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);

        // Stop coincident with snooze expiry goes to idle
        fire("stpexp");
        tick("stpexp_snz", 1'b0, 1'b0, 1'b0, 1'b1, 3'b010);
        tick("stpexp_s1", 1'b1, 1'b0, 1'b0, 1'b0, 3'b010);
        tick("stpexp_s2", 1'b1, 1'b0, 1'b0, 1'b0, 3'b010);
        tick("stpexp_end", 1'b1, 1'b0, 1'b1, 1'b0, 3'b000);

        // Disarm mid-ring and mid-snooze, then no ring while alarm is off
        fire("disarm");
        tick("disarm_tone", 1'b0, 1'b1, 1'b0, 1'b0, 3'b101);
        ALARM_STATE = NOT_ALARM_DURING;
        tick("disarm_ring", 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
        ALARM_STATE = ALARM_DURING;
        fire("disarm2");
        tick("disarm2_snz", 1'b0, 1'b0, 1'b0, 1'b1, 3'b010);
        ALARM_STATE = ALARM_OFF;
        tick("disarm_snz", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        set_time(8'h07, 8'h29, 8'h59);
        tick("off_pre", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        set_time(8'h07, 8'h30, 8'h00);
        tick("off_match", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        tick("off_hold", 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
        ALARM_STATE = ALARM_DURING;

        // Async reset mid-ring clears outputs between edges
        fire("rst");
        tick("rst_tone", 1'b0, 1'b1, 1'b0, 1'b0, 3'b101);
        #2 RESET = 1'b1;
        #1 chk("rst_async", {RINGING, SNOOZING, BUZZER}, 3'b000);
        set_time(8'h07, 8'h29, 8'h59);
        @(negedge CLK);
        RESET = 1'b0;
        tick("rst_idle", 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
        set_time(8'h07, 8'h30, 8'h00);
        tick("rst_fresh", 1'b1, 1'b0, 1'b0, 1'b0, 3'b100);
        tick("rst_stop", 1'b0, 1'b1, 1'b1, 1'b0, 3'b000);

        // Upper hour nibble differs: 17:30 must not match 07:30
        set_time(8'h17, 8'h29, 8'h59);
        tick("h17_pre", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        set_time(8'h17, 8'h30, 8'h00);
        tick("h17_match", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        tick("h17_hold", 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
